// File: rtl/pwm_generator.sv
// 8-bit free-running PWM generator: 256-clock period, registered pwm_out and period_start.
// Define PWM_GENERATOR_SHADOW_EN to latch duty only at period boundaries (glitch-free update).
module pwm_generator (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty,
  output logic       pwm_out,
  output logic       period_start
);

  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic       wrap;
  logic [7:0] duty_eff;

  assign cnt_next = cnt + 8'd1;
  assign wrap     = (cnt_next == 8'd0);

`ifdef PWM_GENERATOR_SHADOW_EN
  logic [7:0] duty_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow <= 8'd0;
    end else if (wrap) begin
      duty_shadow <= duty;
    end
  end

  // At the wrap edge the shadow is being loaded this same edge, so compare against
  // the incoming duty; the cnt == 0 cycle then already reflects the new value.
  assign duty_eff = wrap ? duty : duty_shadow;
`else
  assign duty_eff = duty;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 8'd0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      pwm_out      <= (cnt_next < duty_eff);
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator; reference model tracks position within the period.
// Build with PWM_GENERATOR_SHADOW_EN defined to check the shadowed-duty variant.
module tb_pwm_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] duty = 8'd0;
  logic       pwm_out;
  logic       period_start;

  int checks = 0;
  int errors = 0;

  // Reference model: position inside the 256-clock period and the threshold in force.
  int m_pos    = 0;
  int m_shadow = 0;
  bit exp_pwm  = 1'b0;
  bit exp_ps   = 1'b0;

`ifdef PWM_GENERATOR_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  always #5 clk = ~clk;

  pwm_generator dut (
    .clk         (clk),
    .rst         (rst),
    .duty        (duty),
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

  // Advance one clock, update the model from the inputs seen at that edge, settle.
  task automatic step();
    int thr;
    @(posedge clk);
    if (rst) begin
      m_pos    = 0;
      m_shadow = 0;
      exp_pwm  = 1'b0;
      exp_ps   = 1'b0;
    end else begin
      m_pos = (m_pos + 1) % 256;
      if (SHADOW) begin
        if (m_pos == 0) m_shadow = int'(duty);
        thr = m_shadow;
      end else begin
        thr = int'(duty);
      end
      exp_pwm = (m_pos < thr);
      exp_ps  = (m_pos == 0);
    end
    #1;
  endtask

  // Step until the model sits at the requested period position, comparing every cycle.
  task automatic align_to(input int pos, input string tag);
    for (int n = 0; n < 300 && m_pos != pos; n++) begin
      step();
      checks++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        errors++;
        $display("FAIL %s_align pos=%0d pwm=%b/%b ps=%b/%b (actual/required)",
                 tag, m_pos, pwm_out, exp_pwm, period_start, exp_ps);
      end
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    duty = 8'd64;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (pwm_out !== 1'b0 || period_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d pwm=%b ps=%b required 0/0", i, pwm_out, period_start);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (pwm_out !== (SHADOW ? 1'b0 : 1'b1) || period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge pwm=%b ps=%b required %b/0",
               pwm_out, period_start, SHADOW ? 1'b0 : 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        errors++;
        $display("FAIL reset_run pos=%0d pwm=%b/%b ps=%b/%b", m_pos, pwm_out, exp_pwm,
                 period_start, exp_ps);
      end
    end
  endtask

  task automatic test_steady();
    bit prev;
    int hi;
    int pulses;
    duty = 8'd64;
    align_to(255, "steady");
    for (int p = 0; p < 3; p++) begin
      hi = 0;
      pulses = 0;
      for (int i = 0; i < 256; i++) begin
        prev = pwm_out;
        step();
        checks++;
        if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
          errors++;
          $display("FAIL steady_cycle pos=%0d pwm=%b/%b ps=%b/%b", m_pos, pwm_out, exp_pwm,
                   period_start, exp_ps);
        end
        if (pwm_out === 1'b1) hi++;
        if (period_start === 1'b1) begin
          pulses++;
          checks++;
          if (!(prev == 1'b0 && pwm_out === 1'b1)) begin
            errors++;
            $display("FAIL steady_rise_coincident prev=%b pwm=%b required 0->1", prev, pwm_out);
          end
        end
      end
      checks++;
      if (hi != 64 || pulses != 1) begin
        errors++;
        $display("FAIL steady_period p=%0d high=%0d pulses=%0d required 64/1", p, hi, pulses);
      end
    end
  endtask

  task automatic test_boundaries();
    int vals[4];
    int hi;
    vals[0] = 0;
    vals[1] = 255;
    vals[2] = 1;
    vals[3] = int'($urandom_range(2, 254));
    foreach (vals[v]) begin
      duty = vals[v][7:0];
      align_to(255, "bound");
      hi = 0;
      for (int i = 0; i < 256; i++) begin
        step();
        checks++;
        // Position i of a period with constant D: high exactly when i < D.
        if (pwm_out !== (i < vals[v]) || period_start !== (i == 0)) begin
          errors++;
          $display("FAIL bound_cycle duty=%0d pos=%0d pwm=%b/%b ps=%b/%b", vals[v], i,
                   pwm_out, (i < vals[v]), period_start, (i == 0));
        end
        if (pwm_out === 1'b1) hi++;
      end
      checks++;
      if (hi != vals[v]) begin
        errors++;
        $display("FAIL bound_high_count duty=%0d high=%0d required %0d", vals[v], hi, vals[v]);
      end
    end
  endtask

  task automatic test_mid_change();
    int new_duty;
    int fall_pos;
    int hi_rest;
    int hi;
    new_duty = SHADOW ? 192 : 128;
    duty = 8'd64;
    align_to(255, "mid");
    align_to(100, "mid");
    duty = new_duty[7:0];
    fall_pos = -1;
    hi_rest  = 0;
    for (int i = 101; i < 256; i++) begin
      step();
      checks++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        errors++;
        $display("FAIL mid_cycle pos=%0d pwm=%b/%b ps=%b/%b", m_pos, pwm_out, exp_pwm,
                 period_start, exp_ps);
      end
      if (i == 101) begin
        checks++;
        if (pwm_out !== (SHADOW ? 1'b0 : 1'b1)) begin
          errors++;
          $display("FAIL mid_first_edge pwm=%b required %b", pwm_out, SHADOW ? 1'b0 : 1'b1);
        end
      end
      if (pwm_out === 1'b1) hi_rest++;
      else if (fall_pos < 0) fall_pos = i;
    end
    checks++;
    if (SHADOW ? (hi_rest != 0) : (fall_pos != 128)) begin
      errors++;
      $display("FAIL mid_tail high=%0d fall_pos=%0d required %s", hi_rest, fall_pos,
               SHADOW ? "high 0" : "fall 128");
    end
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (pwm_out === 1'b1) hi++;
    end
    checks++;
    if (hi != new_duty) begin
      errors++;
      $display("FAIL mid_next_period high=%0d required %0d", hi, new_duty);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    duty = 8'd128;
    align_to(255, "rstmid");
    align_to(30, "rstmid");
    rst = 1'b1;
    step();
    checks++;
    if (pwm_out !== 1'b0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort pwm=%b ps=%b required 0/0", pwm_out, period_start);
    end
    rst = 1'b0;
    step();
    checks++;
    if (pwm_out !== (SHADOW ? 1'b0 : 1'b1) || period_start !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_restart pwm=%b ps=%b required %b/0", pwm_out, period_start,
               SHADOW ? 1'b0 : 1'b1);
    end
    pulses = 0;
    for (int i = 2; i < 256; i++) begin
      step();
      if (period_start === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rstmid_spurious_pulse pulses=%0d required 0", pulses);
    end
    step();
    checks++;
    if (period_start !== 1'b1 || pwm_out !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_wrap ps=%b pwm=%b required 1/1", period_start, pwm_out);
    end
  endtask

  task automatic test_random();
    int rst_left;
    rst_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 31) == 0) duty = 8'($urandom);
      if (rst_left > 0) begin
        rst_left--;
        rst = (rst_left > 0);
      end else if ($urandom_range(0, 511) == 0) begin
        rst = 1'b1;
        rst_left = int'($urandom_range(1, 3)) + 1;
      end
      step();
      checks++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        errors++;
        $display("FAIL random_cycle n=%0d pos=%0d duty=%0d pwm=%b/%b ps=%b/%b", n, m_pos,
                 duty, pwm_out, exp_pwm, period_start, exp_ps);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_boundaries();
    test_mid_change();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Port clk  input  1  system clock; all registers use its rising edge.
REQ-003 Port rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 Port duty  input  8  duty-cycle threshold; high time in clocks per 256-clock period.
REQ-005 Port pwm_out  output  1  registered PWM waveform.
REQ-006 Port period_start  output  1  registered one-clock pulse marking count value 0 of each period.
REQ-007 The block SHALL have no parameters; counter and duty widths SHALL be fixed at 8 bits.

Function
REQ-008 An internal 8-bit counter cnt SHALL increment by 1 on every clk edge with rst low, wrapping 255 -> 0 (period = 256 clocks).
REQ-009 cnt_next SHALL equal (cnt + 1) mod 256; cnt SHALL be loaded with cnt_next each non-reset edge.
REQ-010 The effective threshold duty_eff SHALL be duty in the default build; see REQ-018 for the alternative.
REQ-011 On each non-reset edge, pwm_out SHALL be loaded with (cnt_next < duty_eff), unsigned compare, so during the cycle in which cnt == k, pwm_out = (k < duty_eff).
REQ-012 duty = 0 SHALL hold pwm_out low for the whole period; duty = 255 SHALL give 255 high clocks and 1 low clock (cnt == 255); 100% duty is not supported.
REQ-013 Over a full period with constant duty_eff = D, pwm_out SHALL be high for exactly D clocks, contiguous, starting at cnt == 0.
REQ-014 On each non-reset edge, period_start SHALL be loaded with (cnt_next == 0), so it is high only during the cycle in which cnt == 0.
REQ-015 In the default build, a duty change SHALL affect pwm_out on the next clk edge after the new value is sampled, including mid-period; a truncated or extended pulse is permitted.

Reset
REQ-016 While rst is high at a clk edge: cnt <= 0, pwm_out <= 0, period_start <= 0, and the duty shadow register (if built) <= 0, regardless of duty.
REQ-017 Reset asserted mid-period SHALL abort the period; the first edge after rst is deasserted SHALL load cnt = 1 and pwm_out = (1 < duty_eff), so no period_start pulse occurs until the wrap.

Configuration
REQ-018 With macro PWM_GENERATOR_SHADOW_EN defined: an 8-bit shadow register SHALL load duty on each non-reset edge where cnt_next == 0, and duty_eff SHALL be the shadow value, so a duty change takes effect only at the next period boundary (glitch-free).
REQ-019 The shadow load and the pwm_out compare at the wrap edge SHALL use the newly sampled duty, so the cnt == 0 cycle already reflects the new duty.
REQ-020 Without PWM_GENERATOR_SHADOW_EN, no shadow register SHALL exist and duty_eff = duty, per REQ-010 and REQ-015.

Verification
REQ-021 Reset: rst = 1 for 2 clocks with duty = 64 -> pwm_out = 0 and period_start = 0 throughout reset; after release, cnt runs 1, 2, 3 ...
REQ-022 Steady duty = 64 (default build), 3 full periods -> pwm_out high for exactly 64 clocks per 256; period_start pulses every 256 clocks, coincident with the pwm_out rising edge.
REQ-023 Boundaries: duty = 0 -> pwm_out never high; duty = 255 -> pwm_out low only in the cnt == 255 cycle; duty = 1 -> high only in the cnt == 0 cycle.
REQ-024 Mid-period change (default build): duty 64 -> 128 at cnt = 100 -> pwm_out rises at the edge after sampling and falls when cnt reaches 128.
REQ-025 Shadow build: duty 64 -> 192 at cnt = 100 -> pwm_out stays low until the wrap; the next period is high for 192 clocks.
REQ-026 Reset mid-period: rst = 1 at cnt = 30 with duty = 128 -> pwm_out = 0 on the next edge; after release, the counter restarts from 1 with no spurious period_start pulse.
